// File: rtl/ps2_scancode_translator_pkg.sv
// Shared constants for the PS/2 set-2 scancode translator: prefix bytes,
// modifier and special-key scancodes, prefix FSM states and ASCII values.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_TAB    = 8'h0D;
    localparam logic [7:0] SC_ESC    = 8'h76;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } prefix_state_t;

    localparam logic [7:0] ASC_SPACE     = 8'h20;
    localparam logic [7:0] ASC_CR        = 8'h0D;
    localparam logic [7:0] ASC_BS        = 8'h08;
    localparam logic [7:0] ASC_TAB       = 8'h09;
    localparam logic [7:0] ASC_ESC       = 8'h1B;
    localparam logic [7:0] ASC_CTRL_MASK = 8'h1F;
    localparam logic [7:0] ASC_CASE_BIT  = 8'h20;

endpackage

// File: rtl/ps2_scancode_translator_if.sv
// Scancode input and character-FIFO output bundle between the PS/2 decoder
// side, the translator and the 68k bus glue.
interface ps2_scancode_translator_if;
    logic [7:0] code_in;
    logic       code_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] mods;
    logic       overflow;
    logic       ovf_clr;

    modport slave (
        input  code_in, code_valid, out_ready, ovf_clr,
        output out_data, out_valid, mods, overflow
    );

    modport master (
        output code_in, code_valid, out_ready, ovf_clr,
        input  out_data, out_valid, mods, overflow
    );
endinterface

// File: rtl/ps2_scancode_translator_keymap.sv
// Combinational set-2 make-code to ASCII lookup for letters, digits and a
// handful of control keys; hit=0 for any code without a character.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    input  logic       ctrl,
    output logic       hit,
    output logic [7:0] ascii
);

    logic [7:0]  letter;
    logic [15:0] digit;   // {unshifted, shifted}

    always_comb begin
        letter = '0;
        digit  = '0;
        hit    = 1'b0;
        ascii  = '0;
        case (code)
            8'h1C: letter = "A";   8'h32: letter = "B";   8'h21: letter = "C";
            8'h23: letter = "D";   8'h24: letter = "E";   8'h2B: letter = "F";
            8'h34: letter = "G";   8'h33: letter = "H";   8'h43: letter = "I";
            8'h3B: letter = "J";   8'h42: letter = "K";   8'h4B: letter = "L";
            8'h3A: letter = "M";   8'h31: letter = "N";   8'h44: letter = "O";
            8'h4D: letter = "P";   8'h15: letter = "Q";   8'h2D: letter = "R";
            8'h1B: letter = "S";   8'h2C: letter = "T";   8'h3C: letter = "U";
            8'h2A: letter = "V";   8'h1D: letter = "W";   8'h22: letter = "X";
            8'h35: letter = "Y";   8'h1A: letter = "Z";
            8'h45: digit = "0)";   8'h16: digit = "1!";   8'h1E: digit = "2@";
            8'h26: digit = "3#";   8'h25: digit = "4$";   8'h2E: digit = "5%";
            8'h36: digit = "6^";   8'h3D: digit = "7&";   8'h3E: digit = "8*";
            8'h46: digit = "9(";
            default: ;
        endcase

        if (letter != '0) begin
            hit = 1'b1;
            if (ctrl)
                ascii = letter & ASC_CTRL_MASK;
            else if (shift ^ caps)
                ascii = letter;
            else
                ascii = letter | ASC_CASE_BIT;
        end else if (digit != '0) begin
            hit   = 1'b1;
            ascii = shift ? digit[7:0] : digit[15:8];
        end else begin
            case (code)
                SC_SPACE: begin hit = 1'b1; ascii = ASC_SPACE; end
                SC_ENTER: begin hit = 1'b1; ascii = ASC_CR;    end
                SC_BKSP:  begin hit = 1'b1; ascii = ASC_BS;    end
                SC_TAB:   begin hit = 1'b1; ascii = ASC_TAB;   end
                SC_ESC:   begin hit = 1'b1; ascii = ASC_ESC;   end
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_translator.sv
// Tracks F0/E0 prefixes and modifier keys on validated set-2 bytes, translates
// make codes to ASCII and queues the characters in a small ready/valid FIFO.
module ps2_scancode_translator
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    ps2_scancode_translator_if.slave    bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                prev_v_q, prev_v_d;
    prefix_state_t       state_q, state_d;
    logic                lshift_q, lshift_d, rshift_q, rshift_d;
    logic                lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic                caps_held_q, caps_held_d, caps_lock_q, caps_lock_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          mem_q [DEPTH];

    logic       accept, char_push, push_ok, pop, full;
    logic       km_hit;
    logic [7:0] km_ascii;

    ps2_keymap u_keymap (
        .code  (bus.code_in),
        .shift (lshift_q | rshift_q),
        .caps  (caps_lock_q),
        .ctrl  (lctrl_q | rctrl_q),
        .hit   (km_hit),
        .ascii (km_ascii)
    );

    always_comb begin
        prev_v_d    = bus.code_valid;
        state_d     = state_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        caps_held_d = caps_held_q;
        caps_lock_d = caps_lock_q;
        char_push   = 1'b0;
        accept      = bus.code_valid & ~prev_v_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (bus.code_in == SC_BREAK) begin
                        state_d = BRK;
                    end else if (bus.code_in == SC_EXT) begin
                        state_d = EXT;
                    end else begin
                        // Modifier codes have no keymap entry, so they never push.
                        char_push = km_hit;
                        case (bus.code_in)
                            SC_LSHIFT: lshift_d = 1'b1;
                            SC_RSHIFT: rshift_d = 1'b1;
                            SC_CTRL:   lctrl_d  = 1'b1;
                            SC_CAPS: begin
                                if (!caps_held_q)
                                    caps_lock_d = ~caps_lock_q;
                                caps_held_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    case (bus.code_in)
                        SC_LSHIFT: lshift_d    = 1'b0;
                        SC_RSHIFT: rshift_d    = 1'b0;
                        SC_CTRL:   lctrl_d     = 1'b0;
                        SC_CAPS:   caps_held_d = 1'b0;
                        default: ;
                    endcase
                end
                EXT: begin
                    if (bus.code_in == SC_BREAK) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                        if (bus.code_in == SC_CTRL)
                            rctrl_d = 1'b1;
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (bus.code_in == SC_CTRL)
                        rctrl_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        full       = (count_q == (PTR_W+1)'(DEPTH));
        pop        = (count_q != '0) & bus.out_ready;
        push_ok    = char_push & (~full | pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear must leave the flag set.
        if (char_push && !push_ok)
            overflow_d = 1'b1;
        else if (bus.ovf_clr)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_v_q    <= 1'b0;
            state_q     <= IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            caps_held_q <= 1'b0;
            caps_lock_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            prev_v_q    <= prev_v_d;
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            caps_held_q <= caps_held_d;
            caps_lock_q <= caps_lock_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= km_ascii;
    end

    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_valid = (count_q != '0);
    assign bus.mods      = {caps_lock_q, lctrl_q | rctrl_q, lshift_q | rshift_q};
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_translator.sv
// Directed bench: a table of single-byte vectors with expected modifiers and
// characters, followed by hand-written overflow, reset and held-level sequences.
module tb_ps2_scancode_translator;

    typedef struct {
        logic [7:0] code;
        logic [2:0] mods;
        logic       has_char;
        logic [7:0] ch;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    ps2_scancode_translator_if bus();

    ps2_scancode_translator #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] code, input logic [2:0] mods,
                       input logic has_char, input logic [7:0] ch);
        vec_t v;
        v.code = code; v.mods = mods; v.has_char = has_char; v.ch = ch;
        vecs.push_back(v);
    endtask

    // Returns at the negedge after the acceptance edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.code_in    = b;
        bus.code_valid = 1'b1;
        @(negedge clk);
        bus.code_valid = 1'b0;
    endtask

    task automatic pop_one(input logic [7:0] exp, input string name);
        chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({name, "_data"}, {24'd0, bus.out_data}, {24'd0, exp});
        $display("pop data=%02h", bus.out_data);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.code_in = '0; bus.code_valid = 1'b0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;

        add(8'h1C,3'b000,1,8'h61); add(8'hF0,3'b000,0,0); add(8'h1C,3'b000,0,0);
        add(8'h12,3'b001,0,0); add(8'h1C,3'b001,1,8'h41); add(8'hF0,3'b001,0,0);
        add(8'h12,3'b000,0,0); add(8'h1C,3'b000,1,8'h61);
        add(8'h58,3'b100,0,0); add(8'h58,3'b100,0,0); add(8'hF0,3'b100,0,0);
        add(8'h58,3'b100,0,0); add(8'h1C,3'b100,1,8'h41); add(8'h58,3'b000,0,0);
        add(8'hF0,3'b000,0,0); add(8'h58,3'b000,0,0); add(8'h1C,3'b000,1,8'h61);
        add(8'hE0,3'b000,0,0); add(8'h14,3'b010,0,0); add(8'h32,3'b010,1,8'h02);
        add(8'hE0,3'b010,0,0); add(8'hF0,3'b010,0,0); add(8'h14,3'b000,0,0);
        add(8'h32,3'b000,1,8'h62); add(8'hE0,3'b000,0,0); add(8'h75,3'b000,0,0);
        add(8'h16,3'b000,1,8'h31); add(8'h59,3'b001,0,0); add(8'h59,3'b001,0,0);
        add(8'h16,3'b001,1,8'h21); add(8'h45,3'b001,1,8'h29); add(8'hF0,3'b001,0,0);
        add(8'h59,3'b000,0,0); add(8'h45,3'b000,1,8'h30);
        add(8'h29,3'b000,1,8'h20); add(8'h5A,3'b000,1,8'h0D); add(8'h66,3'b000,1,8'h08);
        add(8'h0D,3'b000,1,8'h09); add(8'h76,3'b000,1,8'h1B);
        add(8'h14,3'b010,0,0); add(8'h1B,3'b010,1,8'h13); add(8'hF0,3'b010,0,0);
        add(8'h14,3'b000,0,0);
        add(8'h58,3'b100,0,0); add(8'hF0,3'b100,0,0); add(8'h58,3'b100,0,0);
        add(8'h12,3'b101,0,0); add(8'h1C,3'b101,1,8'h61); add(8'hF0,3'b101,0,0);
        add(8'h12,3'b100,0,0); add(8'h58,3'b000,0,0); add(8'hF0,3'b000,0,0);
        add(8'h58,3'b000,0,0);

        // Reset state, sampled while reset is still asserted.
        @(negedge clk);
        chk("rst_mods", {29'd0, bus.mods}, 32'd0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            send_byte(vecs[i].code);
            $display("vec %0d code=%02h mods=%03b valid=%0b data=%02h",
                     i, vecs[i].code, bus.mods, bus.out_valid, bus.out_data);
            chk($sformatf("v%0d_mods", i), {29'd0, bus.mods}, {29'd0, vecs[i].mods});
            chk($sformatf("v%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].has_char});
            if (vecs[i].has_char) begin
                pop_one(vecs[i].ch, $sformatf("v%0d", i));
                chk($sformatf("v%0d_empty", i), {31'd0, bus.out_valid}, 32'd0);
            end
        end

        // Fill past capacity, then push and pop together while full.
        for (int k = 0; k < 5; k++) begin
            send_byte(8'h1C);
            $display("fill %0d valid=%0b ovf=%0b", k, bus.out_valid, bus.overflow);
        end
        chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
        @(negedge clk);
        chk("full_head", {24'd0, bus.out_data}, 32'h61);
        bus.code_in = 8'h2C; bus.code_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.code_valid = 1'b0; bus.out_ready = 1'b0;
        $display("push+pop at full ovf=%0b", bus.overflow);
        chk("ovf_hold", {31'd0, bus.overflow}, 32'd1);
        pop_one(8'h61, "drain0");
        pop_one(8'h61, "drain1");
        pop_one(8'h61, "drain2");
        pop_one(8'h74, "drain3");
        chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        $display("ovf_clr ovf=%0b", bus.overflow);
        chk("ovf_clr", {31'd0, bus.overflow}, 32'd0);

        // Reset in the middle of a shift press and a break prefix.
        send_byte(8'h12);
        send_byte(8'hF0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_mods", {29'd0, bus.mods}, 32'd0);
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        reset = 1'b0;
        send_byte(8'h1C);
        $display("post-reset 1C valid=%0b data=%02h", bus.out_valid, bus.out_data);
        pop_one(8'h61, "postrst");
        chk("postrst_empty", {31'd0, bus.out_valid}, 32'd0);

        // A held code_valid level yields exactly one character.
        @(negedge clk);
        bus.code_in = 8'h29; bus.code_valid = 1'b1;
        repeat (10) @(negedge clk);
        bus.code_valid = 1'b0;
        @(negedge clk);
        $display("held level valid=%0b data=%02h", bus.out_valid, bus.out_data);
        pop_one(8'h20, "held");
        chk("held_single", {31'd0, bus.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_translator.md
Name: ps2_scancode_translator

Overview:
- Downstream consumer of the PS/2 frame decoder.
- Takes validated set-2 scancode bytes and tracks the F0 (break) and E0 (extended) prefixes.
- Maintains shift, ctrl and caps-lock state and translates make codes of printable/control keys to ASCII.
- Buffers the characters in a small FIFO with a ready/valid interface toward the 68k bus glue.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  reset, asynchronous, active-high.
- code_in  in  8  scancode byte from decoder; stable whenever code_valid=1.
- code_valid  in  1  byte-available flag; may be a pulse or a held level. Only its rising edge is consumed.
- out_data  out  8  ASCII character at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer pop; pop occurs on a clk edge where out_valid&out_ready.
- mods  out  3  {caps_lock, ctrl, shift} current state.
- overflow  out  1  sticky; set when a character is dropped because the FIFO is full.
- ovf_clr  in  1  synchronous clear of overflow; a set in the same cycle wins.

Behaviour:
- Reset values: all outputs 0; FIFO empty; prefix state IDLE; all modifiers 0; edge-detect register 0.
- Edge detect: prev_v <= code_valid each cycle. A byte is accepted at edge k iff code_valid=1 and prev_v=0. A level held for many cycles yields exactly one acceptance.
- Prefix FSM (advances only on an accepted byte):
  - IDLE: F0 -> BRK; E0 -> EXT; other -> make(code), stay IDLE.
  - BRK: byte -> break(code) -> IDLE.
  - EXT: F0 -> EXT_BRK; other -> make_ext(code) -> IDLE.
  - EXT_BRK: byte -> break_ext(code) -> IDLE.
  - E0 or F0 received in BRK/EXT_BRK is treated as the key code (no nesting).
- Modifiers:
  - shift = lshift_held | rshift_held; 12 = left shift, 59 = right shift.
  - ctrl = lctrl_held | rctrl_held; 14 = left ctrl, E0 14 = right ctrl.
  - Make sets the held bit; break clears it.
  - caps_lock toggles on make of 58 only if caps_held=0. caps_held is set on make 58 and cleared on break 58, so typematic repeats do not re-toggle.
- Translation (make in IDLE only; extended makes produce no character):
  - Letters: upper case if shift^caps, else lower case.
  - Ctrl + letter -> letter&1F (e.g. ctrl+A = 01), overriding case.
  - Digits: unshifted 0-9; shifted gives US symbols ) ! @ # $ % ^ & * ( .
  - Space 29 -> 20, Enter 5A -> 0D, Backspace 66 -> 08, Tab 0D -> 09, Esc 76 -> 1B.
  - Any unmapped code is silently ignored, including typematic repeats of modifiers.
  - Breaks never produce characters.
- Latency: a character accepted at edge k is written at edge k. out_valid=1 from edge k if the FIFO was empty, and out_data is valid in the same cycle.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr and a PTR_W+1 count; pointers wrap DEPTH-1 -> 0.
  - Push and pop in the same cycle when full: both happen, nothing is dropped, count is unchanged.
  - Push when full with no pop: character dropped, overflow <= 1.
  - Push and pop in the same cycle when empty: push happens, no pop (out_valid was 0).
  - out_data is driven from mem[rd_ptr]; its value while out_valid=0 is don't-care.
- Reset mid-sequence (e.g. after F0): FSM returns to IDLE, modifiers and FIFO are cleared, and the next byte is treated as a fresh code.

Decomposition:
- Package ps2_pkg holds:
  - prefix constants SC_BREAK=F0 and SC_EXT=E0;
  - modifier codes SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_CAPS;
  - FSM state localparams IDLE/BRK/EXT/EXT_BRK;
  - ASCII control constants.
- Sub-module ps2_keymap: combinational scancode+shift+caps+ctrl -> {hit, ascii[7:0]}. It holds the full set-2 letter/digit table (1C=A, 32=B, 21=C, 1B=S, 16=1, 1E=2, 45=0, ...).
- Top level holds the edge detect, FSM, modifiers and FIFO.

Test Plan:
- Send 1C, then F0 1C -> one entry 61 ('a'), out_valid=1; after the pop FIFO is empty, mods=000.
- Send 12, 1C, F0 12, 1C -> entries 41, 61; mods bit0 is 1 between the 12 make and its break.
- Send 58, 58 (repeat), F0 58, 1C, then 58, F0 58, 1C -> entries 41, 61; caps toggles only once per press.
- Send E0 14, 32, E0 F0 14, 32 -> entries 02, 62; E0 75 (extended arrow) -> no entry.
- DEPTH=4, out_ready=0, send 1C x5 -> count=4, overflow=1, entries all 61. Then pop with a simultaneous push at full -> count stays 4. Then ovf_clr -> overflow=0.
- Send F0, assert reset, release, send 1C -> entry 61 (the make is not treated as a break). Hold code_valid high for 10 cycles with 29 -> exactly one 20.
